// File: rtl/fp_normalize_round.sv
// Normalize/round back-end for the FP add/sub datapath: shifts out leading zeros one bit
// per cycle, rounds to nearest-even and emits a packed {sign, exp, fraction} word with flags.
`ifndef EXP_SIZE
`define EXP_SIZE 8
`endif
`ifndef MANTIS_SIZE
`define MANTIS_SIZE 23
`endif

module fp_normalize_round #(
  parameter int EXP_SIZE    = `EXP_SIZE,
  parameter int MANTIS_SIZE = `MANTIS_SIZE
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_sign,
  input  logic [EXP_SIZE-1:0]             in_exp,
  input  logic [MANTIS_SIZE+2:0]          in_mantis,
  input  logic                            in_loss,
  input  logic                            in_operator,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [EXP_SIZE+MANTIS_SIZE:0]   out_result,
  output logic                            out_overflow,
  output logic                            out_underflow,
  output logic                            out_inexact
);

  localparam int MW = MANTIS_SIZE + 3;
  localparam logic [EXP_SIZE-1:0] EXP_ONES = {EXP_SIZE{1'b1}};
  localparam logic [EXP_SIZE-1:0] EXP_ONE  = {{(EXP_SIZE-1){1'b0}}, 1'b1};
  localparam logic [EXP_SIZE-1:0] EXP_ZERO = {EXP_SIZE{1'b0}};
  localparam logic [MW-1:0]       MAN_ZERO = {MW{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                        state_r;
  logic                          ready_r;
  logic                          valid_r;
  logic                          sign_r;
  logic                          sticky_r;
  logic                          op_r;
  logic                          skip_r;
  logic                          ovf_r;
  logic                          unf_r;
  logic                          inx_r;
  logic [EXP_SIZE-1:0]           exp_r;
  logic [MW-1:0]                 mantis_r;
  logic [EXP_SIZE+MANTIS_SIZE:0] result_r;
  logic                          res_ovf_r;
  logic                          res_unf_r;
  logic                          res_inx_r;

  logic                          guard_s;
  logic                          rs_s;
  logic                          up_s;
  logic [MANTIS_SIZE+1:0]        sum_s;
  logic [EXP_SIZE-1:0]           rexp_s;
  logic [MANTIS_SIZE-1:0]        rfrac_s;
  logic                          rovf_s;

  assign in_ready      = ready_r;
  assign out_valid     = valid_r;
  assign out_result    = result_r;
  assign out_overflow  = res_ovf_r;
  assign out_underflow = res_unf_r;
  assign out_inexact   = res_inx_r;

  // Round-to-nearest-even of the normalized mantissa; carry-out bumps the exponent
  always_comb begin
    guard_s = mantis_r[1];
    rs_s    = mantis_r[0] | sticky_r;
    up_s    = guard_s & (rs_s | mantis_r[2]);
    sum_s   = {1'b0, mantis_r[MW-1:2]} + {{(MANTIS_SIZE+1){1'b0}}, up_s};
    rexp_s  = exp_r;
    rfrac_s = sum_s[MANTIS_SIZE-1:0];
    rovf_s  = 1'b0;
    if (sum_s[MANTIS_SIZE+1]) begin
      rexp_s  = exp_r + EXP_ONE;
      rfrac_s = {MANTIS_SIZE{1'b0}};
    end else begin
      rexp_s  = exp_r;
    end
    if (rexp_s == EXP_ONES) begin
      rfrac_s = {MANTIS_SIZE{1'b0}};
      rovf_s  = 1'b1;
    end else begin
      rovf_s  = 1'b0;
    end
  end

  // Control FSM with capture, normalization shift and registered result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      ready_r   <= 1'b0;
      valid_r   <= 1'b0;
      sign_r    <= 1'b0;
      sticky_r  <= 1'b0;
      op_r      <= 1'b0;
      skip_r    <= 1'b0;
      ovf_r     <= 1'b0;
      unf_r     <= 1'b0;
      inx_r     <= 1'b0;
      exp_r     <= EXP_ZERO;
      mantis_r  <= MAN_ZERO;
      result_r  <= {(EXP_SIZE+MANTIS_SIZE+1){1'b0}};
      res_ovf_r <= 1'b0;
      res_unf_r <= 1'b0;
      res_inx_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (ready_r && in_valid) begin
            sign_r   <= in_sign;
            exp_r    <= in_exp;
            mantis_r <= in_mantis;
            sticky_r <= in_loss;
            op_r     <= in_operator;
            skip_r   <= 1'b0;
            ovf_r    <= 1'b0;
            unf_r    <= 1'b0;
            inx_r    <= 1'b0;
            ready_r  <= 1'b0;
            state_r  <= NORM;
          end else begin
            ready_r  <= 1'b1;
          end
        end
        NORM: begin
          // Exponent only moves in the shift branch, so exp_r==0 / all-ones can only hold on entry
          if ((mantis_r == MAN_ZERO) || (exp_r == EXP_ZERO)) begin
            sign_r   <= op_r ? 1'b0 : sign_r;
            exp_r    <= EXP_ZERO;
            mantis_r <= MAN_ZERO;
            skip_r   <= 1'b1;
            state_r  <= ROUND;
          end else if (exp_r == EXP_ONES) begin
            mantis_r <= MAN_ZERO;
            ovf_r    <= 1'b1;
            skip_r   <= 1'b1;
            state_r  <= ROUND;
          end else if (mantis_r[MW-1]) begin
            state_r  <= ROUND;
          end else if (exp_r == EXP_ONE) begin
            exp_r    <= EXP_ZERO;
            mantis_r <= MAN_ZERO;
            unf_r    <= 1'b1;
            inx_r    <= (mantis_r != MAN_ZERO) | sticky_r;
            skip_r   <= 1'b1;
            state_r  <= ROUND;
          end else begin
            mantis_r <= {mantis_r[MW-2:0], 1'b0};
            exp_r    <= exp_r - EXP_ONE;
          end
        end
        ROUND: begin
          if (skip_r) begin
            result_r  <= {sign_r, exp_r, {MANTIS_SIZE{1'b0}}};
            res_ovf_r <= ovf_r;
            res_unf_r <= unf_r;
            res_inx_r <= inx_r;
          end else begin
            result_r  <= {sign_r, rexp_s, rfrac_s};
            res_ovf_r <= rovf_s;
            res_unf_r <= 1'b0;
            res_inx_r <= guard_s | rs_s;
          end
          valid_r <= 1'b1;
          state_r <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            valid_r <= 1'b0;
            ready_r <= 1'b1;
            state_r <= IDLE;
          end else begin
            valid_r <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          ready_r <= 1'b0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalize_round.sv
// Randomized and directed bench for fp_normalize_round against a value-level rounding model.
module tb_fp_normalize_round;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [25:0] in_mantis;
  logic        in_loss;
  logic        in_operator;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_inexact;

  int checks = 0;
  int failures = 0;
  logic [31:0] obs_res;
  logic [2:0]  obs_flags;
  int          obs_lat;

  fp_normalize_round #(.EXP_SIZE(8), .MANTIS_SIZE(23)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mantis(in_mantis),
    .in_loss(in_loss), .in_operator(in_operator),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_overflow(out_overflow), .out_underflow(out_underflow), .out_inexact(out_inexact)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Value-level model: find the leading one, decide normal vs underflow, then round RNE
  task automatic model(input logic s, input logic [7:0] e, input logic [25:0] m,
                       input logic loss, input logic op,
                       output logic [31:0] res, output logic [2:0] flags, output int lat);
    int k;
    int ee;
    logic [25:0] mm;
    logic [24:0] v;
    logic g;
    logic r;
    flags = 3'b000;
    lat = 2;
    if (m == 26'd0 || e == 8'd0) begin
      res = {(op ? 1'b0 : s), 31'd0};
    end else if (e == 8'hFF) begin
      res = {s, 8'hFF, 23'd0};
      flags = 3'b100;
    end else begin
      k = 0;
      while (!m[25-k]) k++;
      if (int'(e) - k >= 1) begin
        mm = m << k;
        ee = int'(e) - k;
        lat = 2 + k;
        v = {1'b0, mm[25:2]};
        g = mm[1];
        r = mm[0] | loss;
        if (g && (r || v[0])) v = v + 25'd1;
        if (v[24]) begin
          v = v >> 1;
          ee++;
        end
        if (ee == 255) begin
          res = {s, 8'hFF, 23'd0};
          flags = {1'b1, 1'b0, g | r};
        end else begin
          res = {s, 8'(ee), v[22:0]};
          flags = {1'b0, 1'b0, g | r};
        end
      end else begin
        res = {s, 31'd0};
        flags = 3'b011;
        lat = 2 + int'(e) - 1;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                        input logic [25:0] m, input logic loss, input logic op, input int hold);
    logic [31:0] exp_res;
    logic [2:0]  exp_flags;
    int          exp_lat;
    int          n;
    model(s, e, m, loss, op, exp_res, exp_flags, exp_lat);
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq({tag, "_in_ready"}, in_ready, 1);
    in_sign = s; in_exp = e; in_mantis = m; in_loss = loss; in_operator = op;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sign = $urandom; in_exp = $urandom; in_mantis = $urandom; in_loss = $urandom;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid && n < 200);
    obs_res = out_result;
    obs_flags = {out_overflow, out_underflow, out_inexact};
    obs_lat = n;
    check_eq({tag, "_valid"}, out_valid, 1);
    check_eq({tag, "_latency"}, n, exp_lat);
    check_eq({tag, "_result"}, out_result, exp_res);
    check_eq({tag, "_flags"}, obs_flags, exp_flags);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq({tag, "_hold_res"}, out_result, obs_res);
      check_eq({tag, "_hold_flags"}, {out_overflow, out_underflow, out_inexact}, obs_flags);
      check_eq({tag, "_hold_valid"}, out_valid, 1);
      check_eq({tag, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({tag, "_valid_drop"}, out_valid, 0);
  endtask

  initial begin
    int seen;
    logic [7:0]  re;
    logic [25:0] rm;
    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = 8'd0; in_mantis = 26'd0;
    in_loss = 1'b0; in_operator = 1'b0; out_ready = 1'b0;
    #1;
    check_eq("reset_in_ready", in_ready, 0);
    check_eq("reset_out", {out_valid, out_result, out_overflow, out_underflow, out_inexact}, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    run_op("pass", 1'b0, 8'h7F, 26'h2000000, 1'b0, 1'b0, 0);
    check_eq("pass_const", obs_res, 32'h3F800000);
    check_eq("pass_lat_const", obs_lat, 2);
    run_op("cancel", 1'b0, 8'h7F, 26'h0000004, 1'b0, 1'b1, 0);
    check_eq("cancel_const", obs_res, 32'h34000000);
    check_eq("cancel_lat_const", obs_lat, 25);
    run_op("carry", 1'b0, 8'h7F, 26'h3FFFFFE, 1'b0, 1'b0, 0);
    check_eq("carry_const", {obs_res, obs_flags}, {32'h40000000, 3'b001});
    run_op("tie", 1'b0, 8'h7F, 26'h2000002, 1'b0, 1'b0, 0);
    check_eq("tie_const", {obs_res, obs_flags}, {32'h3F800000, 3'b001});
    run_op("ovf", 1'b0, 8'hFE, 26'h3FFFFFE, 1'b0, 1'b0, 0);
    check_eq("ovf_const", {obs_res, obs_flags}, {32'h7F800000, 3'b101});
    run_op("zero", 1'b1, 8'h00, 26'h0000000, 1'b0, 1'b1, 0);
    check_eq("zero_const", {obs_res, obs_flags}, {32'h00000000, 3'b000});
    run_op("unf", 1'b0, 8'h03, 26'h0000004, 1'b0, 1'b0, 0);
    check_eq("unf_const", {obs_res, obs_flags[2:1]}, {32'h00000000, 2'b01});
    run_op("backpressure", 1'b1, 8'h85, 26'h0123457, 1'b1, 1'b1, 10);

    // Reset in the middle of a long normalization
    in_sign = 1'b0; in_exp = 8'h7F; in_mantis = 26'h0000004; in_loss = 1'b0; in_operator = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst_in_ready", in_ready, 0);
    check_eq("midrst_out", {out_valid, out_result, out_overflow, out_underflow, out_inexact}, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check_eq("midrst_no_valid", seen, 0);
    run_op("after_rst", 1'b0, 8'h7F, 26'h0000004, 1'b0, 1'b1, 0);

    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 9))
        0:       re = 8'h00;
        1:       re = 8'hFF;
        2, 3:    re = 8'($urandom_range(1, 6));
        4:       re = 8'($urandom_range(250, 254));
        default: re = 8'($urandom_range(1, 254));
      endcase
      rm = 26'($urandom) >> $urandom_range(0, 25);
      if ($urandom_range(0, 3) == 0) rm[25] = 1'b1;
      run_op("rand", 1'($urandom), re, rm, 1'($urandom), 1'($urandom), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fp_normalize_round.md
Name: fp_normalize_round

Overview:
- Back-end stage for the FP add/sub datapath. Consumes the raw aligned-sum result of the mantissa adder: sign, exponent, extended mantissa with guard/round bits, sticky loss, and operator.
- Left-normalizes iteratively, one bit per cycle, after subtractive cancellation.
- Rounds to nearest-even and emits a packed IEEE-style word with exception flags.
- Valid/ready on both sides, so it can sit between the adder and the result register or bus.

Parameters:
- EXP_SIZE, default `EXP_SIZE (8): exponent width.
- MANTIS_SIZE, default `MANTIS_SIZE (23): stored fraction width.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input handshake valid.
- in_ready  output  1  input handshake ready.
- in_sign  input  1  result sign from adder.
- in_exp  input  EXP_SIZE  result exponent from adder.
- in_mantis  input  MANTIS_SIZE+3  layout: [M+2]=hidden, [M+1:2]=fraction, [1]=guard, [0]=round.
- in_loss  input  1  sticky bit (OR of bits lost in alignment/shift).
- in_operator  input  1  1 = effective subtraction.
- out_valid  output  1  output handshake valid.
- out_ready  input  1  output handshake ready.
- out_result  output  1+EXP_SIZE+MANTIS_SIZE  packed as {sign, exp, fraction}.
- out_overflow  output  1  result saturated to infinity.
- out_underflow  output  1  result flushed to zero.
- out_inexact  output  1  guard|round|sticky nonzero at rounding.

Behaviour:
- Reset (async, rst=1): state=IDLE; in_ready=0 while rst is high; all other outputs 0; internal registers cleared. Reset mid-operation discards the operation; no output is produced.
- FSM states: IDLE, NORM, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge E0, capture all inputs; sticky=in_loss; go to NORM.
- NORM (in_ready=0), one decision per cycle:
  - mantis==0, or captured in_exp==0: zero result. Sign = 0 if in_operator=1, else in_sign; exp=0, frac=0. Go to ROUND, with rounding suppressed.
  - Captured in_exp all-ones: output infinity, overflow=1. Go to ROUND, with rounding suppressed.
  - hidden==1: go to ROUND.
  - exp==1 and hidden==0: flush to signed zero, underflow=1; inexact = (mantis!=0)|sticky. Go to ROUND.
  - Otherwise: mantis <<= 1 (zero in at LSB), exp -= 1, stay in NORM.
  - k = number of shift cycles, 0..MANTIS_SIZE+2.
- ROUND, one cycle, round-to-nearest-even:
  - lsb=mantis[2], g=mantis[1], rs=mantis[0]|sticky.
  - up = g & (rs|lsb).
  - {hidden,frac} += up. On carry-out: frac=0, exp+=1.
  - If exp becomes all-ones: frac=0, overflow=1.
  - inexact = g|rs.
  - Register outputs; go to DONE.
- DONE:
  - out_valid=1; out_result and flags are stable while out_valid=1 and out_ready=0.
  - On out_ready=1: clear out_valid, go to IDLE.
  - A new input is accepted no earlier than the cycle after the output handshake (no overlap).
- Latency: out_valid rises after edge E0+2+k.
  - Already-normalized input: out_valid rises after edge E0+2.
- Flags are valid only with out_valid and are held with out_result.
- Exponent arithmetic never wraps:
  - decrement is bounded by the exp==1 underflow check;
  - increment is bounded by the all-ones overflow check.

Test Plan (EXP_SIZE=8, MANTIS_SIZE=23):
- Normalized pass-through: in_sign=0, in_exp=8'h7F, in_mantis=26'h2000000, loss=0 -> out_result=32'h3F800000 at E0+2; all flags 0.
- Full cancellation shift: in_exp=8'h7F, in_mantis=26'h0000004, in_operator=1 -> 23 NORM shifts; out_result=32'h34000000; out_valid after E0+25.
- Rounding carry:
  - in_exp=8'h7F, in_mantis=26'h3FFFFFE, loss=0 -> out_result=32'h40000000, inexact=1.
  - Tie-to-even: in_mantis=26'h2000002 -> out_result=32'h3F800000, inexact=1.
- Overflow and zero:
  - in_exp=8'hFE, in_mantis=26'h3FFFFFE -> out_result=32'h7F800000, overflow=1, inexact=1.
  - in_sign=1, in_operator=1, in_exp=0, in_mantis=0 -> out_result=32'h00000000, flags 0.
- Underflow: in_exp=8'h03, in_mantis=26'h0000004 -> 2 shifts reach exp==1 with hidden=0 -> out_result=32'h00000000, underflow=1.
- Backpressure/reset:
  - Hold out_ready=0 for 10 cycles -> out_result and flags stable, in_ready=0 throughout.
  - Assert rst during NORM of the cancellation case -> outputs 0 immediately; no out_valid afterward; the next operation completes normally.
